// File: rtl/pool_scale_relu.sv
// pool_scale_relu: FP16 divide-by-2^SHIFT, optional ReLU, 2-entry FIFO, position tags.
// Optional feature: define POOL_RELU_EN to rectify negative results to +0.
module pool_scale_relu #(
  parameter int MAP_W = 12,
  parameter int MAP_H = 12,
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [3:0]  out_row,
  output logic [3:0]  out_col,
  output logic        frame_done
);

  logic [15:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        alive;
  logic        push;
  logic        pop;
  logic [15:0] scaled;
  logic [15:0] result;
  logic        last_pos;

  // Exact power-of-two scaling by exponent arithmetic, truncating toward zero.
  function automatic logic [15:0] scale(input logic [15:0] d);
    logic        s;
    logic [4:0]  e;
    logic [9:0]  m;
    logic [10:0] mm;
    logic [4:0]  sh;
    logic [15:0] r;
    s  = d[15];
    e  = d[14:10];
    m  = d[9:0];
    mm = '0;
    sh = '0;
    if (e == 5'd31) begin
      r = d;
    end else if (e > 5'(SHIFT)) begin
      r = {s, e - 5'(SHIFT), m};
    end else if (e != 5'd0) begin
      sh = 5'(SHIFT) - e + 5'd1;
      mm = {1'b1, m} >> sh;
      r  = {s, 5'd0, mm[9:0]};
    end else begin
      r = {s, 5'd0, m >> SHIFT};
    end
    return r;
  endfunction

  // Scale the incoming value and optionally rectify it before it enters the FIFO.
  always_comb begin
    scaled = scale(in_data);
    result = scaled;
`ifdef POOL_RELU_EN
    if (scaled[15] && scaled[14:10] != 5'd31) begin
      result = 16'h0000;
    end
`else
    result = scaled;
`endif
  end

  assign in_ready  = alive && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign last_pos  = (out_row == 4'(MAP_H - 1)) &&
                     (out_col == 4'(MAP_W - 1));

  // Input side enables one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head-element position, advanced only on an output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && last_pos;
      if (pop) begin
        if (out_col == 4'(MAP_W - 1)) begin
          out_col <= '0;
          if (out_row == 4'(MAP_H - 1)) begin
            out_row <= '0;
          end else begin
            out_row <= out_row + 4'd1;
          end
        end else begin
          out_col <= out_col + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_scale_relu.sv
// tb_pool_scale_relu: scoreboard bench for pool_scale_relu.
// Expected values pushed at stimulus time, checked by a negedge monitor.
module tb_pool_scale_relu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
  } exp_t;

  exp_t q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   n_pos     = 0;
  int   fd_count  = 0;
  bit   prev_last = 0;

  pool_scale_relu #(.MAP_W(12), .MAP_H(12), .SHIFT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare each output handshake against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_last = 0;
    end else begin
      if (prev_last || frame_done)
        check("frame_done", 16'(frame_done), 16'(prev_last));
      if (frame_done) fd_count++;
      prev_last = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", out_data, 16'hxxxx);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_row", 16'(out_row), 16'(e.row));
          check("out_col", 16'(out_col), 16'(e.col));
          prev_last = (e.row == 4'd11) && (e.col == 4'd11);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] x);
    exp_t e;
    int   k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 16'(in_ready), 16'd1);
    end else begin
      e.data = x;
      e.row  = 4'(n_pos / 12);
      e.col  = 4'(n_pos % 12);
      q.push_back(e);
      n_pos = (n_pos + 1) % 144;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) check("drain_timeout", 16'(q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  logic [15:0] vin [4];
  logic [15:0] vout [4];
  logic [15:0] neg_exp;
  logic [15:0] nz_exp;

  initial begin
    vin[0] = 16'h4400; vout[0] = 16'h3C00;
    vin[1] = 16'h0800; vout[1] = 16'h0200;
    vin[2] = 16'h0004; vout[2] = 16'h0001;
    vin[3] = 16'h7E00; vout[3] = 16'h7E00;
`ifdef POOL_RELU_EN
    neg_exp = 16'h0000;
    nz_exp  = 16'h0000;
`else
    neg_exp = 16'hBC00;
    nz_exp  = 16'h8000;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_row", 16'(out_row), 16'd0);
    check("rst_out_col", 16'(out_col), 16'd0);
    check("rst_frame_done", 16'(frame_done), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 16'(in_ready), 16'd1);

    out_ready = 1'b1;
    send(vin[0], vout[0]);
    check("latency_valid", 16'(out_valid), 16'd1);
    check("latency_data", out_data, 16'h3C00);
    for (int i = 1; i < 4; i++) send(vin[i], vout[i]);
    send(16'hC400, neg_exp);
    send(16'h8000, nz_exp);
    drain();

    out_ready = 1'b0;
    send(16'h4400, 16'h3C00);
    send(16'h4800, 16'h4000);
    check("bp_in_ready", 16'(in_ready), 16'd0);
    check("bp_hold_data", out_data, 16'h3C00);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_data2", out_data, 16'h3C00);
    check("bp_hold_col", 16'(out_col), 16'd6);
    check("bp_in_ready2", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_back", 16'(in_ready), 16'd1);

    for (int i = 0; i < 136; i++) send(vin[i % 4], vout[i % 4]);
    drain();
    check("frame_pulses", 16'(fd_count), 16'd1);
    check("frame_row0", 16'(out_row), 16'd0);
    check("frame_col0", 16'(out_col), 16'd0);

    fd_count = 0;
    for (int i = 0; i < 50; i++) send(vin[i % 4], vout[i % 4]);
    drain();
    out_ready = 1'b0;
    send(16'h4400, 16'h3C00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_data", out_data, 16'h0000);
    check("mid_rst_row", 16'(out_row), 16'd0);
    check("mid_rst_col", 16'(out_col), 16'd0);
    check("mid_rst_ready", 16'(in_ready), 16'd0);
    q.delete();
    n_pos = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 144; i++) send(vin[i % 4], vout[i % 4]);
    drain();
    check("frame2_pulses", 16'(fd_count), 16'd1);
    check("frame2_row0", 16'(out_row), 16'd0);
    check("frame2_col0", 16'(out_col), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
